// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, glitch-rejecting start check, parity/framing/overrun
// flags and a valid/ready output. Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions.
module uart_rx_param #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_BITS);
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned MAJ = 1;
`else
    localparam int unsigned MAJ = 0;
`endif
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] START_CHK = CW'(OVERSAMPLE / 2 - 1 + MAJ);
    localparam logic [CW-1:0] CNT_AFTER = CW'(MAJ);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 pend_q, pend_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 fa_q, fa_d;
    logic                 pa_q, pa_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 rx_s, bit_val, decide, complete;

    assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // Two previous tick samples; the vote is taken one tick after the nominal centre.
    logic [1:0] hist_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      hist_q <= '1;
        else if (s_tick) hist_q <= {hist_q[0], rx_s};
    end
    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '1;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            shift_q <= '0;
            fa_q    <= 1'b0;
            pa_q    <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            shift_q <= shift_d;
            fa_q    <= fa_d;
            pa_q    <= pa_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        shift_d  = shift_q;
        fa_d     = fa_q;
        pa_d     = pa_q;
        dout_d   = dout_q;
        valid_d  = valid_q & ~dout_ready;
        ferr_d   = ferr_q;
        perr_d   = perr_q;
        ovr_d    = 1'b0;
        decide   = 1'b0;
        complete = 1'b0;
        if (s_tick) begin
            unique case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    if (cnt_q == START_CHK) begin
                        if (!bit_val) begin
                            state_d = DATA;
                            cnt_d   = CNT_AFTER;
                            idx_d   = '0;
                            pend_d  = 1'b0;
                            fa_d    = 1'b0;
                            pa_d    = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA, PARITY, STOP: begin
                    // With majority voting the mid-bit tick only arms a decision for the following tick.
                    if (MAJ != 0 && pend_q) begin
                        decide = 1'b1;
                        pend_d = 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (MAJ != 0) pend_d = 1'b1;
                        else          decide = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (decide) begin
                        cnt_d = CNT_AFTER;
                        case (state_q)
                            DATA: begin
                                shift_d[idx_q] = bit_val;
                                if (idx_q == LAST_BIT) begin
                                    idx_d   = '0;
                                    state_d = (PARITY_MODE != 0) ? PARITY : STOP;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                            PARITY: begin
                                pa_d    = (PARITY_MODE == 1) ? ((^shift_q) != bit_val)
                                                             : ((~^shift_q) != bit_val);
                                state_d = STOP;
                            end
                            default: begin
                                fa_d = fa_q | ~bit_val;
                                if (idx_q == LAST_STOP) begin
                                    complete = 1'b1;
                                    state_d  = IDLE;
                                end else begin
                                    idx_d = idx_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (complete) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shift_d;
                ferr_d  = fa_d;
                perr_d  = pa_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = ferr_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule
